// File: rtl/frame_sequencer_if.sv
// Valid/ready pixel stream feeding the frame sequencer, with start-of-frame and end-of-row markers.
interface frame_sequencer_if #(
  parameter int PIXEL_SIZE = 24
);
  logic                  valid;
  logic                  ready;
  logic [PIXEL_SIZE-1:0] data;
  logic                  sof;
  logic                  eol;

  modport master (output valid, data, sof, eol, input ready);
  modport slave  (input valid, data, sof, eol, output ready);
endinterface

// File: rtl/frame_sequencer.sv
// Drives the detection datapath from a pixel stream: sync insertion, end-of-frame flush,
// and realignment of the datapath output into a registered valid stream.
//
// state  | meaning
// IDLE   | waiting for sof; non-sof beats are dropped
// VSYNC  | one new-frame strobe cycle into the datapath
// ACTIVE | forwarding pixels of the current row
// HSYNC  | one new-row strobe cycle between rows
// FLUSH  | zero-data cycles draining the row buffers
module frame_sequencer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int PIXEL_SIZE   = 24,
  parameter int FLUSH_CYCLES = 1924
) (
  input  logic                  clk,
  input  logic                  reset,
  frame_sequencer_if.slave      s,
  output logic                  pipe_en,
  output logic                  pipe_hsync,
  output logic                  pipe_vsync,
  output logic [PIXEL_SIZE-1:0] pipe_data,
  input  logic [PIXEL_SIZE-1:0] pipe_out,
  output logic                  m_valid,
  output logic [PIXEL_SIZE-1:0] m_data,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  err_framing
);
  localparam int COL_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(FRAME_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    ACTIVE = 3'd2,
    HSYNC  = 3'd3,
    FLUSH  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] en_cnt;
  logic [CNT_W-1:0] en_cnt_d;
  logic             en_d;
  logic             ready;
  logic             take;
  logic             col_end;

  assign col_end = (col == COL_LAST);
  assign s.ready = ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    take       = 1'b0;
    pipe_en    = 1'b0;
    pipe_hsync = 1'b0;
    pipe_vsync = 1'b0;
    pipe_data  = '0;
    case (state)
      IDLE: begin
        // sof is held off for one cycle so it is consumed as the first ACTIVE pixel
        ready = !(s.valid && s.sof);
        if (s.valid && s.sof) state_nxt = VSYNC;
      end
      VSYNC: begin
        pipe_en    = 1'b1;
        pipe_vsync = 1'b1;
        state_nxt  = ACTIVE;
      end
      ACTIVE: begin
        ready = 1'b1;
        if (s.valid) begin
          take      = 1'b1;
          pipe_en   = 1'b1;
          pipe_data = s.data;
          if (col_end) state_nxt = (row == ROW_LAST) ? FLUSH : HSYNC;
        end
      end
      HSYNC: begin
        pipe_en    = 1'b1;
        pipe_hsync = 1'b1;
        state_nxt  = ACTIVE;
      end
      FLUSH: begin
        pipe_en = 1'b1;
        if (flush_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      flush_cnt   <= '0;
      en_cnt      <= '0;
      en_cnt_d    <= '0;
      en_d        <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      err_framing <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      en_d       <= pipe_en;
      en_cnt_d   <= en_cnt;
      if (state == IDLE)                     en_cnt <= '0;
      else if (pipe_en && en_cnt != CNT_MAX) en_cnt <= en_cnt + 1'b1;

      // the first FLUSH_CYCLES enables only fill the datapath; outputs after that are real
      m_valid <= en_d && (en_cnt_d >= CNT_MAX);
      if (en_d) m_data <= pipe_out;

      case (state)
        VSYNC: begin
          col <= '0;
          row <= '0;
        end
        ACTIVE: begin
          if (take) begin
            if (col_end) begin
              col       <= '0;
              flush_cnt <= FLUSH_LOAD;
            end else begin
              col <= col + 1'b1;
            end
            if ((s.eol != col_end) || (s.sof && (col != '0 || row != '0)))
              err_framing <= 1'b1;
          end
        end
        HSYNC: row <= row + 1'b1;
        FLUSH: begin
          if (flush_cnt == '0) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a one-register stand-in for the detection datapath.
module tb_frame_sequencer;
  localparam int FW = 4;
  localparam int FH = 3;
  localparam int PS = 24;
  localparam int FC = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pipe_en, pipe_hsync, pipe_vsync;
  logic [PS-1:0] pipe_data;
  logic [PS-1:0] pipe_out = '0;
  logic          m_valid;
  logic [PS-1:0] m_data;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic          err_framing;

  int n_chk = 0;
  int n_err = 0;

  int n_en, n_vs, n_hs, n_mv, n_done, sum_pd, hs_pos0, hs_pos1, mdata_bad, sync_bad;

  frame_sequencer_if #(.PIXEL_SIZE(PS)) s_if ();

  frame_sequencer #(
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .PIXEL_SIZE  (PS),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (s_if),
    .pipe_en    (pipe_en),
    .pipe_hsync (pipe_hsync),
    .pipe_vsync (pipe_vsync),
    .pipe_data  (pipe_data),
    .pipe_out   (pipe_out),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err_framing(err_framing)
  );

  always #5 clk = ~clk;

  // datapath stand-in: one cycle latency, distinctive value when not enabled
  always @(posedge clk) pipe_out <= pipe_en ? pipe_data + 24'd1 : 24'hDEAD00;

  always @(negedge clk) begin
    if (!reset) begin
      if (pipe_en) begin
        n_en   = n_en + 1;
        sum_pd = sum_pd + int'(pipe_data);
        if (pipe_vsync) n_vs = n_vs + 1;
        if (pipe_hsync) begin
          n_hs = n_hs + 1;
          if (n_hs == 1) hs_pos0 = n_en;
          if (n_hs == 2) hs_pos1 = n_en;
        end
      end else if (pipe_hsync || pipe_vsync) begin
        sync_bad = sync_bad + 1;
      end
      if (m_valid) begin
        n_mv = n_mv + 1;
        if (m_data != 24'd1) mdata_bad = mdata_bad + 1;
      end
      if (frame_done) n_done = n_done + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_en = 0; n_vs = 0; n_hs = 0; n_mv = 0; n_done = 0;
    sum_pd = 0; hs_pos0 = 0; hs_pos1 = 0; mdata_bad = 0; sync_bad = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic push(input logic [PS-1:0] d, input logic sof, input logic eol, output int stalls);
    int n = 0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.sof   = sof;
    s_if.eol   = eol;
    @(negedge clk);
    while (!s_if.ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("push_timeout", n, 0);
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    s_if.sof   = 1'b0;
    s_if.eol   = 1'b0;
    stalls = n;
  endtask

  task automatic send_frame(input int seed, input bit toggle, input int err_col,
                            output int sum, output int stall0);
    int st;
    int gap_en = 0;
    sum = 0;
    stall0 = 0;
    for (int r = 0; r < FH; r++) begin
      for (int c = 0; c < FW; c++) begin
        int v = seed * 16 + r * FW + c + 1;
        bit mark_err = (r == 0) && (c == err_col);
        if (mark_err) check("err_before", err_framing, 0);
        push(PS'(v), (r == 0 && c == 0), (c == FW - 1) || mark_err, st);
        if (r == 0 && c == 0) stall0 = st;
        if (mark_err) check("err_after", err_framing, 1);
        sum += v;
        if (toggle) begin
          @(negedge clk);
          if (c != FW - 1 && pipe_en) gap_en++;
          @(posedge clk);
          #1;
        end
      end
    end
    if (toggle) check("gap_en", gap_en, 0);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (n_done < target && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("done_in_time", n < 400, 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic frame_checks(input int exp_frames, input int exp_sum);
    check("n_en", n_en, 31);
    check("n_vsync", n_vs, 1);
    check("n_hsync", n_hs, 2);
    check("hsync_pos0", hs_pos0, 6);
    check("hsync_pos1", hs_pos1, 11);
    check("n_mvalid", n_mv, 15);
    check("n_done", n_done, 1);
    check("frame_cnt", frame_cnt, exp_frames);
    check("pix_sum", sum_pd, exp_sum);
    check("m_data_bad", mdata_bad, 0);
    check("sync_wo_en", sync_bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sum, st0, st, sumb, st0b, disc;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.sof   = 1'b0;
    s_if.eol   = 1'b0;
    clr_mon();

    // 1: reset state
    do_reset();
    @(negedge clk);
    check("rst_pipe_en", pipe_en, 0);
    check("rst_hsync", pipe_hsync, 0);
    check("rst_vsync", pipe_vsync, 0);
    check("rst_pipe_data", pipe_data, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err", err_framing, 0);
    check("rst_s_ready", s_if.ready, 1);
    @(posedge clk);
    #1;

    // 2: clean frame
    clr_mon();
    send_frame(1, 1'b0, -1, sum, st0);
    wait_done(1);
    check("c2_sof_stall", st0, 2);
    frame_checks(1, sum);
    check("c2_err", err_framing, 0);

    // 3: s_valid toggling in ACTIVE
    clr_mon();
    send_frame(2, 1'b1, -1, sum, st0);
    wait_done(1);
    frame_checks(2, sum);
    check("c3_err", err_framing, 0);

    // 4: stray beats before sof are dropped
    clr_mon();
    disc = 0;
    for (int i = 0; i < 5; i++) begin
      push(PS'(24'h777 + i), 1'b0, 1'b0, st);
      disc += st;
    end
    @(negedge clk);
    check("c4_disc_stall", disc, 0);
    check("c4_disc_en", n_en, 0);
    @(posedge clk);
    #1;
    send_frame(3, 1'b0, -1, sum, st0);
    wait_done(1);
    frame_checks(3, sum);

    // 5: early eol on column 2 of row 0
    clr_mon();
    send_frame(4, 1'b0, 2, sum, st0);
    wait_done(1);
    frame_checks(4, sum);
    check("c5_err_sticky", err_framing, 1);

    // 6: reset on the 6th pixel abandons the frame
    clr_mon();
    for (int i = 0; i < 5; i++) push(PS'(i + 1), (i == 0), (i == FW - 1), st);
    s_if.valid = 1'b1;
    s_if.data  = 24'h66;
    reset      = 1'b1;
    @(negedge clk);
    check("c6_ready_at_rst", s_if.ready, 1);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    s_if.valid = 1'b0;
    @(negedge clk);
    check("c6_pipe_en", pipe_en, 0);
    check("c6_m_valid", m_valid, 0);
    check("c6_frame_cnt", frame_cnt, 0);
    check("c6_err", err_framing, 0);
    check("c6_s_ready", s_if.ready, 1);
    @(posedge clk);
    #1;
    clr_mon();
    send_frame(5, 1'b0, -1, sum, st0);
    wait_done(1);
    frame_checks(1, sum);

    // 7: sof held during FLUSH, back-to-back frames
    do_reset();
    clr_mon();
    send_frame(6, 1'b0, -1, sum, st0);
    send_frame(7, 1'b0, -1, sumb, st0b);
    wait_done(2);
    check("c7_first_stall", st0, 2);
    check("c7_flush_stall", st0b, FC + 2);
    check("c7_n_en", n_en, 62);
    check("c7_n_vsync", n_vs, 2);
    check("c7_n_mvalid", n_mv, 30);
    check("c7_n_done", n_done, 2);
    check("c7_frame_cnt", frame_cnt, 2);
    check("c7_pix_sum", sum_pd, sum + sumb);
    check("c7_m_data_bad", mdata_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
